// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit driving a byte-addressed word memory port
//
// Purpose: accepts one load or store at a time, checks width, alignment and range,
// performs the memory access (read-modify-write for SB/SH), and returns a one-cycle
// completion pulse with the extended load data or an error flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_funct3    store/load select and RV32I width code
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    load result (0 for stores/errors), rejection flag
//   mem_EnWR              memory write enable (high only while writing)
//   mem_ABus, mem_DBusW   memory byte address and write word
//   mem_DBusR             memory read word, combinational from mem_ABus

module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_EnWR,
  output logic [31:0] mem_ABus,
  output logic [31:0] mem_DBusW,
  input  logic [31:0] mem_DBusR
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        we;
  logic [2:0]  funct3;
  // Only the low half of the store data is ever merged into a read word;
  // SW data goes straight to mem_DBusW at accept time.
  logic [15:0] wdata_lo;

  assign req_ready = (state == IDLE);
  assign mem_EnWR  = (state == WR);

  function automatic logic req_error(input logic w, input logic [2:0] f,
                                     input logic [31:0] a);
    logic bad_code;
    bad_code = w ? (f > 3'b010) : (f == 3'b011 || f[2:1] == 2'b11);
    return bad_code
        || (f[1:0] == 2'b01 && a[0])
        || (f[1:0] == 2'b10 && a[1:0] != 2'b00)
        || (a > MAX_ADDR);
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we        <= 1'b0;
      funct3    <= 3'b000;
      wdata_lo  <= 16'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_ABus  <= 32'h0;
      mem_DBusW <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we       <= req_we;
            funct3   <= req_funct3;
            wdata_lo <= req_wdata[15:0];
            if (req_error(req_we, req_funct3, req_addr)) begin
              // Rejected requests never touch the memory port.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (req_we && req_funct3 == 3'b010) begin
              state     <= WR;
              mem_ABus  <= req_addr;
              mem_DBusW <= req_wdata;
            end else begin
              // Loads, and SB/SH which must first read the word they patch.
              state    <= RD;
              mem_ABus <= req_addr;
            end
          end
        end
        RD: begin
          if (we) begin
            mem_DBusW <= funct3[0] ? {mem_DBusR[31:16], wdata_lo}
                                   : {mem_DBusR[31:8], wdata_lo[7:0]};
            state     <= WR;
          end else begin
            rsp_rdata <= load_ext(funct3, mem_DBusR);
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WR: begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit

module tb_load_store_unit;

  localparam int MEM = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_EnWR;
  logic [31:0] mem_ABus, mem_DBusW, mem_DBusR;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  logic [7:0] mem     [MEM];
  logic [7:0] ref_mem [MEM];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_EnWR(mem_EnWR), .mem_ABus(mem_ABus), .mem_DBusW(mem_DBusW),
    .mem_DBusR(mem_DBusR)
  );

  logic [11:0] ia;
  assign ia = mem_ABus[11:0];
  assign mem_DBusR = {mem[ia + 12'd3], mem[ia + 12'd2], mem[ia + 12'd1], mem[ia]};

  always @(posedge clk) begin
    if (mem_EnWR) begin
      for (int k = 0; k < 4; k++) mem[ia + 12'(k)] <= mem_DBusW[8*k +: 8];
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural model: a request either errors, or reads/writes `size`
  // bytes of a flat byte array; latency depends only on the request kind.
  task automatic model(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] r,
                       output int lat);
    int size;
    logic legal;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f[1:0];
    e = !legal || ((a & 32'(size - 1)) != 0) || (a > 32'(MEM - 4));
    r = 32'h0;
    if (e) begin
      lat = 1;
    end else if (!w) begin
      for (int i = 0; i < size; i++) r = r | (32'(ref_mem[a + 32'(i)]) << (8 * i));
      if (!f[2] && size < 4 && r[8*size-1]) r = r | (~32'h0 << (8 * size));
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    logic e;
    logic [31:0] r;
    int exp_lat, lat, wr0;
    model(w, f, a, d, e, r, exp_lat);
    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = w; req_funct3 = f; req_addr = a; req_wdata = d;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, 32'(rsp_err), 32'(e));
    check({tag, " rdata"}, rsp_rdata, r);
    if (e) check({tag, " no write"}, 32'(wr_count), 32'(wr0));
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, " rdata hold"}, rsp_rdata, r);
  endtask

  initial begin
    logic e;
    logic [31:0] r, a;
    int lat, wr0, issued, got, last;
    logic [31:0] q[$];

    for (int i = 0; i < MEM; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst enwr", 32'(mem_EnWR), 32'd0);
    check("rst abus", mem_ABus, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    do_req(1, 3'b010, 32'h100, 32'hDEADBEEF, "sw100");
    do_req(0, 3'b010, 32'h100, 32'h0, "lw100");
    do_req(1, 3'b000, 32'h101, 32'h000000AA, "sb101");
    do_req(0, 3'b010, 32'h100, 32'h0, "lw100 after sb");
    check("sb merge", {ref_mem[32'h103], ref_mem[32'h102], ref_mem[32'h101], ref_mem[32'h100]},
          32'hDEADAAEF);
    do_req(1, 3'b010, 32'h100, 32'hDEADBEEF, "sw100 again");
    do_req(0, 3'b000, 32'h100, 32'h0, "lb");
    do_req(0, 3'b100, 32'h100, 32'h0, "lbu");
    do_req(0, 3'b001, 32'h102, 32'h0, "lh");
    do_req(0, 3'b101, 32'h102, 32'h0, "lhu");
    do_req(0, 3'b010, 32'h102, 32'h0, "lw misaligned");
    do_req(1, 3'b001, 32'h103, 32'h1234, "sh misaligned");
    do_req(0, 3'b010, 32'hFFD, 32'h0, "lw range");
    do_req(0, 3'b011, 32'h100, 32'h0, "load f3 011");
    do_req(1, 3'b000, 32'hFFD, 32'h55, "sb range");
    do_req(1, 3'b001, 32'hFFC, 32'h7777, "sh top");

    // Reset during the read phase of an SB must abort it without a write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h200;
    req_wdata = 32'h5A5A5A5A;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("sb200 in rd", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst ready", 32'(req_ready), 32'd1);
    check("arst rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst rdata", rsp_rdata, 32'h0);
    check("arst err", 32'(rsp_err), 32'd0);
    check("arst enwr", 32'(mem_EnWR), 32'd0);
    check("arst abus", mem_ABus, 32'h0);
    check("arst dbusw", mem_DBusW, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("arst no rsp", 32'(rsp_valid), 32'd0);
    end
    check("arst no write", 32'(wr_count), 32'(wr0));
    @(negedge clk); rst_n = 1'b1;
    do_req(0, 3'b010, 32'h200, 32'h0, "lw200 after reset");

    // Back-to-back loads with req_valid held high.
    issued = 0; got = 0; last = 0;
    req_we = 1'b0; req_funct3 = 3'b010;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (q.size() > 0) check("b2b data", rsp_rdata, q.pop_front());
        else check("b2b extra rsp", 32'(rsp_valid), 32'd0);
        got++;
      end
      if (req_ready) begin
        if (issued < 6) begin
          if (issued > 0) check("b2b spacing", 32'(cyc - last), 32'd3);
          last = cyc;
          a = 32'($urandom_range(0, MEM - 4)) & ~32'h3;
          req_addr = a; req_valid = 1'b1;
          model(1'b0, 3'b010, a, 32'h0, e, r, lat);
          q.push_back(r);
          issued++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b responses", 32'(got), 32'd6);

    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? $urandom : 32'($urandom_range(0, MEM - 1));
      if (sel > 0 && sel < 6) a = a & ~32'h3;
      do_req(1'($urandom), 3'($urandom), a, $urandom, "rand");
    end

    for (int i = 0; i < MEM; i++) begin
      if (mem[i] !== ref_mem[i]) check("final mem", 32'(mem[i]), 32'(ref_mem[i]));
    end
    check("final mem bytes differing", 32'(failures), 32'(failures));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
